// File: rtl/cell_arc_exerciser.sv
// Stimulus/check engine for a 3-input combinational cell: walks all 64 from->to
// vector arcs, samples the cell output at the end of each phase and counts mismatches.
module cell_arc_exerciser #(
  parameter int          SETTLE_CYC = 2,
  parameter logic [7:0]  TRUTH      = 8'h01,
  parameter int          ERR_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             qn,
  output logic             in1,
  output logic             in2,
  output logic             in3,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [ERR_W-1:0] err_cnt,
  output logic [6:0]       first_err
);

  localparam int              CNT_W       = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {IDLE, FROM, TO, FIN} state_t;

  state_t           state, state_nxt;
  logic [5:0]       arc;
  logic [5:0]       arc_inc;
  logic [CNT_W-1:0] settle;
  logic [2:0]       vec;
  logic             launch;
  logic             phase_end;
  logic             last_arc;
  logic             mismatch;

  assign launch    = start && (state == IDLE || state == FIN);
  assign phase_end = (state == FROM || state == TO) && (settle == '0);
  assign last_arc  = (arc == 6'd63);
  assign arc_inc   = arc + 6'd1;
  assign mismatch  = phase_end && (qn != TRUTH[vec]);

  // Vector bits come straight from a register so the cell sees no decode glitches.
  assign {in3, in2, in1} = vec;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: next-state is defaulted before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, FIN: if (start)          state_nxt = FROM;
      FROM:      if (settle == '0)   state_nxt = TO;
      TO:        if (settle == '0)   state_nxt = last_arc ? FIN : FROM;
      default:                       state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == FROM) || (state == TO);
    done = (state == FIN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arc       <= '0;
      settle    <= '0;
      vec       <= '0;
      err_cnt   <= '0;
      fail      <= 1'b0;
      first_err <= '0;
    end else if (launch) begin
      arc       <= '0;
      settle    <= SETTLE_LOAD;
      vec       <= '0;
      err_cnt   <= '0;
      fail      <= 1'b0;
      first_err <= '0;
    end else if (phase_end) begin
      settle <= SETTLE_LOAD;
      if (mismatch) begin
        // A zero count means nothing has been recorded yet in this run.
        if (err_cnt == '0)  first_err <= {arc, state == TO};
        if (err_cnt != '1)  err_cnt   <= err_cnt + ERR_W'(1);
        fail <= 1'b1;
      end
      if (state == FROM) begin
        vec <= arc[2:0];
      end else if (last_arc) begin
        vec <= '0;
      end else begin
        arc <= arc_inc;
        vec <= arc_inc[5:3];
      end
    end else if (busy) begin
      settle <= settle - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_cell_arc_exerciser.sv
// Bench for cell_arc_exerciser: a behavioural cell model closes the loop and a
// queue of expected per-cycle vectors is drained while the engine is busy.
module tb_cell_arc_exerciser;

  logic clk = 1'b0;
  logic rst;

  logic       start_a, qn_a, in1_a, in2_a, in3_a, busy_a, done_a, fail_a;
  logic [7:0] err_a;
  logic [6:0] ferr_a;
  logic [1:0] mode_a;

  logic       start_b, qn_b, in1_b, in2_b, in3_b, busy_b, done_b, fail_b;
  logic [3:0] err_b;
  logic [6:0] ferr_b;
  logic [1:0] mode_b;

  int n_checks = 0;
  int n_fail   = 0;

  logic [2:0] vec_q[$];
  bit         mon_en = 1'b0;
  int         busy_cyc;

  always #5 clk = ~clk;

  // Cell model: 0 = NOR3, 1 = output stuck 0, 2 = output stuck 1.
  function automatic logic cut(input logic [1:0] m, input logic [2:0] v);
    case (m)
      2'd0:    return ~|v;
      2'd1:    return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  always_comb qn_a = cut(mode_a, {in3_a, in2_a, in1_a});
  always_comb qn_b = cut(mode_b, {in3_b, in2_b, in1_b});

  cell_arc_exerciser #(.SETTLE_CYC(2), .TRUTH(8'h01), .ERR_W(8)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .qn(qn_a),
    .in1(in1_a), .in2(in2_a), .in3(in3_a),
    .busy(busy_a), .done(done_a), .fail(fail_a),
    .err_cnt(err_a), .first_err(ferr_a)
  );

  cell_arc_exerciser #(.SETTLE_CYC(1), .TRUTH(8'h01), .ERR_W(4)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .qn(qn_b),
    .in1(in1_b), .in2(in2_b), .in3(in3_b),
    .busy(busy_b), .done(done_b), .fail(fail_b),
    .err_cnt(err_b), .first_err(ferr_b)
  );

  // Advance n falling edges; while monitoring, each busy cycle pops one expected vector.
  task automatic tick_a(input int n);
    logic [2:0] exp_v;
    repeat (n) begin
      @(negedge clk);
      if (mon_en && busy_a) begin
        busy_cyc++;
        n_checks++;
        if (vec_q.size() == 0) begin
          n_fail++;
          $display("FAIL vec_seq: extra busy cycle, got vector %0d, expected none", {in3_a, in2_a, in1_a});
        end else begin
          exp_v = vec_q.pop_front();
          if ({in3_a, in2_a, in1_a} !== exp_v) begin
            n_fail++;
            $display("FAIL vec_seq: got %0d expected %0d (busy cycle %0d)", {in3_a, in2_a, in1_a}, exp_v, busy_cyc);
          end
        end
      end
    end
  endtask

  task automatic push_run_vectors(input int settle);
    logic [5:0] av;
    for (int a = 0; a < 64; a++) begin
      av = 6'(a);
      repeat (settle) vec_q.push_back(av[5:3]);
      repeat (settle) vec_q.push_back(av[2:0]);
    end
  endtask

  task automatic start_a_run();
    @(negedge clk);
    start_a = 1'b1;
    vec_q.delete();
    push_run_vectors(2);
    busy_cyc = 0;
    mon_en   = 1'b1;
    @(posedge clk);
    #1 start_a = 1'b0;
  endtask

  task automatic wait_done_a(input int budget);
    int cyc = 0;
    while (done_a !== 1'b1 && cyc < budget) begin
      tick_a(1);
      cyc++;
    end
    mon_en = 1'b0;
    n_checks++;
    if (done_a !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_a: done=%b after %0d cycles, expected 1", done_a, cyc);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; mode_a = 2'd0; mode_b = 2'd0;
    #12;
    n_checks++;
    if ({in3_a, in2_a, in1_a, busy_a, done_a, fail_a, err_a, ferr_a} !== '0) begin
      n_fail++;
      $display("FAIL reset_a: ins=%b busy=%b done=%b fail=%b err=%0d first=%h, expected all 0",
               {in3_a, in2_a, in1_a}, busy_a, done_a, fail_a, err_a, ferr_a);
    end
    n_checks++;
    if ({in3_b, in2_b, in1_b, busy_b, done_b, fail_b, err_b, ferr_b} !== '0) begin
      n_fail++;
      $display("FAIL reset_b: ins=%b busy=%b done=%b err=%0d, expected all 0",
               {in3_b, in2_b, in1_b}, busy_b, done_b, err_b);
    end
    @(negedge clk);
    rst = 1'b0;
    tick_a(3);
    n_checks++;
    if (busy_a !== 1'b0 || done_a !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_a: busy=%b done=%b, expected 0 0", busy_a, done_a);
    end
  endtask

  // Common end-of-run comparisons for instance A, written out per scenario.
  task automatic test_nor_pass();
    mode_a = 2'd0;
    start_a_run();
    wait_done_a(400);
    n_checks++;
    if (busy_cyc !== 256) begin n_fail++; $display("FAIL nor_busy_len: got %0d expected 256", busy_cyc); end
    n_checks++;
    if (vec_q.size() !== 0) begin n_fail++; $display("FAIL nor_vec_left: got %0d expected 0", vec_q.size()); end
    n_checks++;
    if (err_a !== 8'd0 || fail_a !== 1'b0) begin
      n_fail++; $display("FAIL nor_result: err=%0d fail=%b expected 0 0", err_a, fail_a);
    end
    n_checks++;
    if ({in3_a, in2_a, in1_a} !== 3'd0 || busy_a !== 1'b0) begin
      n_fail++; $display("FAIL nor_fin_outputs: ins=%b busy=%b expected 000 0", {in3_a, in2_a, in1_a}, busy_a);
    end
    tick_a(5);
    n_checks++;
    if (done_a !== 1'b1) begin n_fail++; $display("FAIL nor_done_hold: got %b expected 1", done_a); end
  endtask

  task automatic test_qn0();
    mode_a = 2'd1;
    start_a_run();
    wait_done_a(400);
    n_checks++;
    if (err_a !== 8'd16 || fail_a !== 1'b1 || ferr_a !== 7'd0) begin
      n_fail++;
      $display("FAIL qn0: err=%0d fail=%b first=%h expected 16 1 00", err_a, fail_a, ferr_a);
    end
  endtask

  task automatic test_qn1();
    mode_a = 2'd2;
    start_a_run();
    wait_done_a(400);
    n_checks++;
    if (err_a !== 8'd112 || fail_a !== 1'b1 || ferr_a !== {6'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL qn1: err=%0d fail=%b first=%h expected 112 1 03", err_a, fail_a, ferr_a);
    end
  endtask

  task automatic test_restart_in_fin();
    mode_a = 2'd0;
    start_a_run();
    n_checks++;
    if (done_a !== 1'b0 || busy_a !== 1'b1 || err_a !== 8'd0 || fail_a !== 1'b0 || ferr_a !== 7'd0) begin
      n_fail++;
      $display("FAIL restart_clear: done=%b busy=%b err=%0d fail=%b first=%h expected 0 1 0 0 00",
               done_a, busy_a, err_a, fail_a, ferr_a);
    end
    wait_done_a(400);
    n_checks++;
    if (busy_cyc !== 256 || err_a !== 8'd0) begin
      n_fail++; $display("FAIL restart_run: busy=%0d err=%0d expected 256 0", busy_cyc, err_a);
    end
  endtask

  task automatic test_start_while_busy();
    mode_a = 2'd0;
    start_a_run();
    tick_a(100);
    start_a = 1'b1;
    tick_a(3);
    start_a = 1'b0;
    wait_done_a(400);
    n_checks++;
    if (busy_cyc !== 256 || vec_q.size() !== 0) begin
      n_fail++; $display("FAIL busy_start: busy=%0d left=%0d expected 256 0", busy_cyc, vec_q.size());
    end
  endtask

  task automatic test_rst_midrun();
    mode_a = 2'd1;
    start_a_run();
    tick_a(50);
    n_checks++;
    if (err_a !== 8'd10 || busy_a !== 1'b1) begin
      n_fail++; $display("FAIL midrun_count: err=%0d busy=%b expected 10 1", err_a, busy_a);
    end
    mon_en = 1'b0;
    vec_q.delete();
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({in3_a, in2_a, in1_a} !== 3'd0 || busy_a !== 1'b0 || err_a !== 8'd0 || done_a !== 1'b0 || fail_a !== 1'b0) begin
      n_fail++;
      $display("FAIL midrun_rst: ins=%b busy=%b err=%0d done=%b fail=%b expected 000 0 0 0 0",
               {in3_a, in2_a, in1_a}, busy_a, err_a, done_a, fail_a);
    end
    @(negedge clk);
    rst = 1'b0;
    tick_a(4);
    n_checks++;
    if (done_a !== 1'b0 || busy_a !== 1'b0) begin
      n_fail++; $display("FAIL midrun_idle: done=%b busy=%b expected 0 0", done_a, busy_a);
    end
    mode_a = 2'd0;
    start_a_run();
    wait_done_a(400);
    n_checks++;
    if (busy_cyc !== 256 || err_a !== 8'd0 || vec_q.size() !== 0) begin
      n_fail++;
      $display("FAIL midrun_rerun: busy=%0d err=%0d left=%0d expected 256 0 0", busy_cyc, err_a, vec_q.size());
    end
  endtask

  task automatic run_b(input logic [1:0] m, output int busy_n);
    int cyc = 0;
    busy_n = 0;
    mode_b = m;
    @(negedge clk);
    start_b = 1'b1;
    @(posedge clk);
    #1 start_b = 1'b0;
    while (done_b !== 1'b1 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (busy_b) busy_n++;
    end
    n_checks++;
    if (done_b !== 1'b1) begin
      n_fail++; $display("FAIL timeout_b: done=%b after %0d cycles, expected 1", done_b, cyc);
    end
  endtask

  task automatic test_short_settle();
    int busy_n;
    run_b(2'd0, busy_n);
    n_checks++;
    if (busy_n !== 128 || err_b !== 4'd0 || fail_b !== 1'b0) begin
      n_fail++; $display("FAIL settle1_nor: busy=%0d err=%0d fail=%b expected 128 0 0", busy_n, err_b, fail_b);
    end
    run_b(2'd2, busy_n);
    n_checks++;
    if (err_b !== 4'd15 || fail_b !== 1'b1 || ferr_b !== {6'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL saturate: err=%0d fail=%b first=%h expected 15 1 03", err_b, fail_b, ferr_b);
    end
  endtask

  initial begin
    test_reset();
    test_nor_pass();
    test_qn0();
    test_qn1();
    test_restart_in_fin();
    test_start_while_busy();
    test_rst_midrun();
    test_short_settle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
